// File: rtl/parallel_in_serial_out.sv
// rtl/parallel_in_serial_out.sv - Parallel word to serial bit stream shifter
// One bit per clock, registered outputs, back-to-back words without idle gap.
module parallel_in_serial_out #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic             so_nx, sv_nx, busy_nx, done_nx;
    logic             last_bit, accept;

    assign last_bit   = (state == SHIFT) && (cnt == LAST);
    // Ready while reset is held would let a word slip in on the release edge.
    assign load_ready = rst_n && ((state == IDLE) || last_bit);
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (last_bit && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The first bit is taken straight from load_data so it appears one cycle after accept.
    always_comb begin
        cnt_nx  = cnt;
        sreg_nx = sreg;
        so_nx   = 1'b0;
        sv_nx   = 1'b0;
        busy_nx = 1'b0;
        done_nx = 1'b0;
        if (accept) begin
            cnt_nx  = '0;
            sreg_nx = load_data;
            so_nx   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            sv_nx   = 1'b1;
            busy_nx = 1'b1;
        end else if (state == SHIFT && !last_bit) begin
            cnt_nx  = cnt + 1'b1;
            sreg_nx = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            so_nx   = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
            sv_nx   = 1'b1;
            busy_nx = 1'b1;
            done_nx = (cnt == PRE_LAST);
        end else if (last_bit) begin
            cnt_nx  = '0;
            sreg_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            sreg         <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            cnt          <= cnt_nx;
            sreg         <= sreg_nx;
            serial_out   <= so_nx;
            serial_valid <= sv_nx;
            busy         <= busy_nx;
            done         <= done_nx;
        end
    end
endmodule
